// File: rtl/alu_ui_pkg.sv
// alu_ui_pkg: shared FSM encodings and debounce constants for the ALU front end
package alu_ui_pkg;
    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } db_state_t;
    localparam int DEBOUNCE_DEFAULT = 1000000;
    localparam int SIM_DEBOUNCE     = 4;
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: 2-flop synchroniser plus counting FSM that qualifies level changes and flags accepted presses
module debounce_cell
    import alu_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    output logic level,
    output logic rise_pulse
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [1:0]       sync_q;
    db_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             pulse_q;
    logic             din_s;
    assign din_s = sync_q[1];
    // synchronise the raw input, then accept a change only after DEBOUNCE_CYCLES agreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b00;
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], din_raw};
            pulse_q <= 1'b0;
            case (state_q)
                S_LOW: if (din_s) begin
                    state_q <= S_RISE;
                    cnt_q   <= CNT_W'(1);
                end
                S_RISE: if (!din_s) begin
                    state_q <= S_LOW;
                    cnt_q   <= '0;
                end else if (cnt_q == LAST) begin
                    state_q <= S_HIGH;
                    level_q <= 1'b1;
                    pulse_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                S_HIGH: if (!din_s) begin
                    state_q <= S_FALL;
                    cnt_q   <= CNT_W'(1);
                end
                S_FALL: if (din_s) begin
                    state_q <= S_HIGH;
                    cnt_q   <= '0;
                end else if (cnt_q == LAST) begin
                    state_q <= S_LOW;
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= S_LOW;
            endcase
        end
    end
    assign level      = level_q;
    assign rise_pulse = pulse_q;
endmodule

// File: rtl/alu_input_conditioner.sv
// alu_input_conditioner: synchronises operand switches and debounces load buttons and op switch for top_2bit_alu
module alu_input_conditioner
    import alu_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] inA_raw,
    input  logic [1:0] inB_raw,
    input  logic       btnA_raw,
    input  logic       btnB_raw,
    input  logic       op_raw,
    output logic [1:0] inA,
    output logic [1:0] inB,
    output logic       btnLoadA,
    output logic       btnLoadB,
    output logic       op
);
    logic [1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic       btn_a_level_unused, btn_b_level_unused, op_rise_unused;
    // operand switches only need metastability protection, not debouncing
    always_ff @(posedge clk) begin
        if (rst) begin
            a_s1_q <= 2'b00;
            a_s2_q <= 2'b00;
            b_s1_q <= 2'b00;
            b_s2_q <= 2'b00;
        end else begin
            a_s1_q <= inA_raw;
            a_s2_q <= a_s1_q;
            b_s1_q <= inB_raw;
            b_s2_q <= b_s1_q;
        end
    end
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn_a (
        .clk(clk), .rst(rst), .din_raw(btnA_raw), .level(btn_a_level_unused), .rise_pulse(btnLoadA)
    );
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn_b (
        .clk(clk), .rst(rst), .din_raw(btnB_raw), .level(btn_b_level_unused), .rise_pulse(btnLoadB)
    );
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_op (
        .clk(clk), .rst(rst), .din_raw(op_raw), .level(op), .rise_pulse(op_rise_unused)
    );
    assign inA = a_s2_q;
    assign inB = b_s2_q;
endmodule

// File: tb/tb_alu_input_conditioner.sv
// tb_alu_input_conditioner: directed scenarios plus randomized run against a run-length reference model
module tb_alu_input_conditioner;
    import alu_ui_pkg::*;
    localparam int D = SIM_DEBOUNCE;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] inA_raw = 2'b00, inB_raw = 2'b00;
    logic       btnA_raw = 1'b0, btnB_raw = 1'b0, op_raw = 1'b0;
    logic [1:0] inA, inB;
    logic       btnLoadA, btnLoadB, op;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    alu_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .inA_raw(inA_raw), .inB_raw(inB_raw),
        .btnA_raw(btnA_raw), .btnB_raw(btnB_raw), .op_raw(op_raw),
        .inA(inA), .inB(inB), .btnLoadA(btnLoadA), .btnLoadB(btnLoadB), .op(op)
    );
    // reference: each input is seen two edges late; a level flips once D consecutive
    // samples disagree with it, and a flip to 1 produces a one-cycle pulse
    logic [1:0] ma1, ma2, mb1, mb2;
    logic [2:0] m1, m2, mlvl, mpul;
    int         mrun [3];
    logic [2:0] raw3;
    assign raw3 = {op_raw, btnB_raw, btnA_raw};
    always @(posedge clk) begin
        if (rst) begin
            ma1 <= 0; ma2 <= 0; mb1 <= 0; mb2 <= 0;
            m1 <= 0; m2 <= 0; mlvl <= 0; mpul <= 0;
            for (int i = 0; i < 3; i++) mrun[i] <= 0;
        end else begin
            ma1 <= inA_raw; ma2 <= ma1; mb1 <= inB_raw; mb2 <= mb1;
            m1 <= raw3; m2 <= m1;
            for (int i = 0; i < 3; i++) begin
                if (m2[i] == mlvl[i]) begin
                    mrun[i] <= 0; mpul[i] <= 1'b0;
                end else if (mrun[i] + 1 == D) begin
                    mrun[i] <= 0; mlvl[i] <= ~mlvl[i]; mpul[i] <= ~mlvl[i];
                end else begin
                    mrun[i] <= mrun[i] + 1; mpul[i] <= 1'b0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        inA_raw = 0; inB_raw = 0; btnA_raw = 0; btnB_raw = 0; op_raw = 0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        inA_raw = 2'b11; inB_raw = 2'b10; btnA_raw = 1; btnB_raw = 1; op_raw = 1;
        repeat (3) tick();
        checks += 5;
        if (inA !== 2'b00) begin errors++; $display("FAIL reset_inA got %b exp 00", inA); end
        if (inB !== 2'b00) begin errors++; $display("FAIL reset_inB got %b exp 00", inB); end
        if (btnLoadA !== 1'b0) begin errors++; $display("FAIL reset_btnLoadA got %b exp 0", btnLoadA); end
        if (btnLoadB !== 1'b0) begin errors++; $display("FAIL reset_btnLoadB got %b exp 0", btnLoadB); end
        if (op !== 1'b0) begin errors++; $display("FAIL reset_op got %b exp 0", op); end
        do_reset();
    endtask

    task automatic test_clean_press;
        int first = -1, na = 0, nb = 0;
        do_reset();
        btnA_raw = 1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (btnLoadA === 1'b1) begin na++; if (first < 0) first = e; end
            if (btnLoadB !== 1'b0) nb++;
        end
        btnA_raw = 0;
        repeat (10) tick();
        checks += 3;
        if (first != D + 2) begin errors++; $display("FAIL clean_edge got %0d exp %0d", first, D + 2); end
        if (na != 1) begin errors++; $display("FAIL clean_count got %0d exp 1", na); end
        if (nb != 0) begin errors++; $display("FAIL clean_b_quiet got %0d exp 0", nb); end
    endtask

    task automatic test_bounce;
        logic [5:0] pat = 6'b001101;
        int first = -1, n = 0;
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            btnA_raw = (e <= 6) ? pat[e-1] : 1'b1;
            tick();
            if (btnLoadA === 1'b1) begin n++; if (first < 0) first = e; end
        end
        btnA_raw = 0;
        repeat (8) begin tick(); if (btnLoadA === 1'b1) n++; end
        checks += 2;
        if (first != 12) begin errors++; $display("FAIL bounce_edge got %0d exp 12", first); end
        if (n != 1) begin errors++; $display("FAIL bounce_count got %0d exp 1", n); end
    endtask

    task automatic test_release_bounce;
        logic [2:0] chat = 3'b010;
        int n = 0, first = -1;
        do_reset();
        for (int e = 1; e <= 45; e++) begin
            btnB_raw = (e <= 30) ? 1'b1 : (e <= 33) ? chat[e-31] : 1'b0;
            tick();
            if (btnLoadB === 1'b1) begin n++; if (first < 0) first = e; end
        end
        checks += 2;
        if (first != D + 2) begin errors++; $display("FAIL release_edge got %0d exp %0d", first, D + 2); end
        if (n != 1) begin errors++; $display("FAIL release_count got %0d exp 1", n); end
    endtask

    task automatic test_simultaneous;
        int fa = -1, fb = -1;
        logic [1:0] a_at = 0, b_at = 0;
        do_reset();
        inA_raw = 2'b10; inB_raw = 2'b11;
        repeat (3) tick();
        btnA_raw = 1; btnB_raw = 1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (btnLoadA === 1'b1 && fa < 0) begin fa = e; a_at = inA; b_at = inB; end
            if (btnLoadB === 1'b1 && fb < 0) fb = e;
        end
        btnA_raw = 0; btnB_raw = 0;
        repeat (8) tick();
        checks += 4;
        if (fa != D + 2) begin errors++; $display("FAIL sim_a_edge got %0d exp %0d", fa, D + 2); end
        if (fb != D + 2) begin errors++; $display("FAIL sim_b_edge got %0d exp %0d", fb, D + 2); end
        if (a_at !== 2'd2) begin errors++; $display("FAIL sim_inA got %0d exp 2", a_at); end
        if (b_at !== 2'd3) begin errors++; $display("FAIL sim_inB got %0d exp 3", b_at); end
    endtask

    task automatic test_op;
        logic [3:0] pre = 4'b0011;
        int first = -1, np = 0, early = 0;
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            op_raw = (e <= 4) ? pre[e-1] : 1'b1;
            tick();
            if (op === 1'b1 && first < 0) first = e;
            if (e < 10 && op !== 1'b0) early++;
            if (btnLoadA !== 1'b0 || btnLoadB !== 1'b0) np++;
        end
        checks += 3;
        if (first != 10) begin errors++; $display("FAIL op_edge got %0d exp 10", first); end
        if (early != 0) begin errors++; $display("FAIL op_early got %0d exp 0", early); end
        if (np != 0) begin errors++; $display("FAIL op_no_pulse got %0d exp 0", np); end
        op_raw = 0;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid_count;
        int n_pre = 0, n_rst = 0, n = 0, first = -1;
        do_reset();
        btnA_raw = 1;
        repeat (3) begin tick(); if (btnLoadA === 1'b1) n_pre++; end
        rst = 1;
        repeat (2) begin
            tick();
            if ({inA, inB, btnLoadA, btnLoadB, op} !== 7'd0) n_rst++;
        end
        rst = 0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (btnLoadA === 1'b1) begin n++; if (first < 0) first = e; end
        end
        btnA_raw = 0;
        repeat (8) tick();
        checks += 4;
        if (n_pre != 0) begin errors++; $display("FAIL rmid_pre got %0d exp 0", n_pre); end
        if (n_rst != 0) begin errors++; $display("FAIL rmid_outputs got %0d exp 0", n_rst); end
        if (first != D + 2) begin errors++; $display("FAIL rmid_edge got %0d exp %0d", first, D + 2); end
        if (n != 1) begin errors++; $display("FAIL rmid_count got %0d exp 1", n); end
    endtask

    task automatic test_random;
        logic [6:0] exp_v;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            tick();
            exp_v = {ma2, mb2, mpul[0], mpul[1], mlvl[2]};
            checks++;
            if ({inA, inB, btnLoadA, btnLoadB, op} !== exp_v) begin
                errors++;
                $display("FAIL random_cycle %0d got %b exp %b", c, {inA, inB, btnLoadA, btnLoadB, op}, exp_v);
            end
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) inA_raw = 2'($urandom);
            if ($urandom_range(0, 3) == 0) inB_raw = 2'($urandom);
            if ($urandom_range(0, 5) == 0) btnA_raw = ~btnA_raw;
            if ($urandom_range(0, 5) == 0) btnB_raw = ~btnB_raw;
            if ($urandom_range(0, 5) == 0) op_raw = ~op_raw;
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_simultaneous();
        test_op();
        test_reset_mid_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
